// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: word-addressed program memory loaded while idle,
// PC-driven fetch with valid/ready handshake, redirect/flush and halt detection.
module instr_fetch_unit #(
  parameter int          DEPTH    = 128,
  parameter int          ADDR_W   = 7,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [31:0]       load_data,
  input  logic              start,
  input  logic [ADDR_W:0]   prog_len,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [31:0]       Instruction,
  output logic [31:0]       out_pc,
  output logic              halted,
  output logic              misaligned
);

  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

  localparam logic [ADDR_W:0] DEPTH_LEN = (ADDR_W+1)'(DEPTH);

  state_t            state_reg, state_next;
  logic [31:0]       mem [DEPTH];
  logic [31:0]       pc_reg;
  logic [ADDR_W:0]   len_reg;
  logic              out_valid_reg;
  logic [31:0]       instr_reg;
  logic [31:0]       out_pc_reg;
  logic              misaligned_reg;

  logic              can_issue;
  logic [ADDR_W-1:0] pc_idx;
  logic              pc_oor;
  logic              redir_bad;
  logic              start_ok;
  logic              issue;
  logic [ADDR_W:0]   len_clamped;

  assign can_issue   = !out_valid_reg || out_ready;
  assign pc_idx      = pc_reg[ADDR_W+1:2];
  // Out of range either beyond the memory window or past the program length.
  assign pc_oor      = (pc_reg[31:ADDR_W+2] != '0) || ({1'b0, pc_idx} >= len_reg);
  assign redir_bad   = (redirect_pc[1:0] != 2'b00);
  assign start_ok    = start && !load_en;
  assign issue       = (state_reg == RUN) && !redirect_valid && can_issue && !pc_oor;
  assign len_clamped = (prog_len > DEPTH_LEN) ? DEPTH_LEN : prog_len;

  always_ff @(posedge clk) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (start_ok) state_next = RUN;
      RUN: begin
        if (redirect_valid) begin
          if (redir_bad) state_next = HALT;
        end else if (can_issue && pc_oor) begin
          state_next = HALT;
        end
      end
      default: state_next = HALT;
    endcase
  end

  always_comb begin
    out_valid   = out_valid_reg;
    Instruction = instr_reg;
    out_pc      = out_pc_reg;
    halted      = (state_reg == HALT);
    misaligned  = misaligned_reg;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_reg         <= RESET_PC;
      len_reg        <= '0;
      out_valid_reg  <= 1'b0;
      out_pc_reg     <= '0;
      misaligned_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: if (start_ok) len_reg <= len_clamped;
        RUN: begin
          if (redirect_valid) begin
            // Redirect always flushes the held word, regardless of out_ready.
            out_valid_reg <= 1'b0;
            if (redir_bad) misaligned_reg <= 1'b1;
            else           pc_reg         <= redirect_pc;
          end else if (can_issue) begin
            if (pc_oor) begin
              out_valid_reg <= 1'b0;
            end else begin
              out_valid_reg <= 1'b1;
              out_pc_reg    <= pc_reg;
              pc_reg        <= pc_reg + 32'd4;
            end
          end
        end
        default: out_valid_reg <= 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state_reg == IDLE && load_en) mem[load_addr] <= load_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)     instr_reg <= '0;
    else if (issue) instr_reg <= mem[pc_idx];
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Instruction fetch stage directly upstream of the CPU datapath. Holds a word-addressed instruction memory, programmed through a load port while idle. Runs a program counter and presents one 32-bit instruction per cycle on Instruction with a valid/ready handshake. Supports branch redirect with flush, backpressure, and halt at end of program or on a misaligned target.

Parameters:
DEPTH, 128, instruction memory depth in 32-bit words (power of two).
ADDR_W, 7, word index width, log2(DEPTH).
RESET_PC, 32'h00000000, byte address of the first fetch after start (word aligned).

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
load_en  input  1  write load_data to mem[load_addr]; honoured in IDLE only
load_addr  input  ADDR_W  word index for load
load_data  input  32  instruction word for load
start  input  1  IDLE->RUN; latches prog_len
prog_len  input  ADDR_W+1  number of valid words; values above DEPTH are clamped to DEPTH
redirect_valid  input  1  branch/jump redirect request, 1-cycle pulse
redirect_pc  input  32  redirect byte address
out_ready  input  1  CPU accepts the current Instruction
out_valid  output  1  Instruction/out_pc hold a valid fetched word
Instruction  output  32  fetched instruction to CPU
out_pc  output  32  byte address of Instruction
halted  output  1  fetch terminated
misaligned  output  1  sticky; halt was caused by a redirect with redirect_pc[1:0]!=0

Behaviour:
- Clock and reset:
  - Single clock clk. Reset is synchronous, active-low (rst_n sampled on the rising edge).
  - On reset: state=IDLE, pc=RESET_PC, out_valid=0, Instruction=0, out_pc=0, halted=0, misaligned=0, latched length=0.
  - Memory contents are not reset.
  - Reset mid-RUN aborts the run; the previously loaded program is retained.
- States: IDLE, RUN, HALT.
- IDLE:
  - load_en writes the memory at the clock edge.
  - start takes effect on the next edge: state=RUN, len=min(prog_len,DEPTH).
  - If load_en and start are asserted in the same cycle, the load is performed and start is ignored.
  - redirect_valid is ignored.
- RUN:
  - Define can_issue = !out_valid || out_ready.
  - Priority 1, redirect_valid=1:
    - If redirect_pc[1:0]!=0: state=HALT, misaligned=1, halted=1, out_valid=0.
    - Otherwise: pc=redirect_pc, out_valid=0 (flushes the held word, even if out_ready=1 that cycle).
    - No fetch is issued this cycle. The first redirected word is valid 2 edges after the redirect edge.
  - Priority 2, can_issue=1 and pc[ADDR_W+1:2] >= len (or pc[31:ADDR_W+2]!=0): state=HALT, halted=1, out_valid=0.
  - Priority 3, can_issue=1: Instruction=mem[pc[ADDR_W+1:2]], out_pc=pc, out_valid=1, pc=pc+4.
    - Latency is 1 cycle from pc to Instruction.
    - Throughput is 1 word/cycle while out_ready=1.
  - can_issue=0 (stall): Instruction, out_pc, out_valid and pc are all held stable.
  - load_en and start are ignored.
- HALT:
  - out_valid=0, halted=1. Instruction and out_pc keep their last values.
  - All inputs except rst_n are ignored. Only reset exits HALT.
- Boundary conditions:
  - len=0: HALT on the first RUN edge; out_valid is never asserted.
  - Last word is held under backpressure: the halt check waits until that word is consumed.
  - A redirect to a target >= len causes HALT on the next issue attempt.
  - pc increment uses 32-bit wrap. Out-of-range indices never access the memory.

Test Plan:
- Normal run: load mem[0..3]=0x11111111,0x22222222,0x33333333,0x44444444; start with prog_len=4; out_ready=1 -> out_valid=1 on 4 consecutive cycles with out_pc=0,4,8,C and matching words; the next cycle out_valid=0, halted=1.
- Backpressure: same program; drop out_ready for 3 cycles while 0x22222222 is valid -> Instruction=0x22222222, out_pc=4 stable; resume -> 0x33333333 next; no word is skipped or duplicated.
- Redirect: 8-word program, out_ready=1; pulse redirect_valid with redirect_pc=0x14 while out_pc=0x4 -> out_valid=0 for one cycle, then out_pc=0x14,0x18,0x1C, then halt.
- Misaligned redirect: redirect_pc=0x6 during RUN -> next edge halted=1, misaligned=1, out_valid=0; later redirects and start pulses have no effect.
- Zero length and clamp: prog_len=0 -> halted after one edge, no valid. prog_len=DEPTH+1 -> exactly DEPTH words delivered, then halt.
- Reset mid-run: assert rst_n=0 after 2 delivered words -> all outputs return to 0 and state is IDLE; start again without reloading -> the identical sequence from 0x11111111 is delivered.
